// File: rtl/cc_itf_pkg.sv
// Shared constants and state encodings for the UART memory loader.
package cc_itf_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE, ADDR, LEN, DATA, WRITE, CKSUM, DONE, ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, LSB first.
// byte_vld / frame_err are single-cycle pulses at the stop-bit sample point.
module uart_rx_byte
    import cc_itf_pkg::*;
#(
    parameter int BIT_DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CW = $clog2(BIT_DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_DIV - 1);

    rx_state_e      state, state_nxt;
    logic           rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic           cnt_hit;

    // Synchroniser plus one history flop for falling-edge detection; idle high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) {rx_meta, rx_sync, rx_prev} <= 3'b111;
        else         {rx_meta, rx_sync, rx_prev} <= {rx_i, rx_meta, rx_sync};
    end

    // Start bit is checked half a bit in; everything else one full bit apart
    assign cnt_hit = (state == RX_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= RX_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: glitchy start bits fall back to idle
    always_comb begin
        state_nxt = state;
        unique case (state)
            RX_IDLE:  if (rx_prev && !rx_sync) state_nxt = RX_START;
            RX_START: if (cnt_hit) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_hit && bit_idx == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (cnt_hit) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    // Bit timer, data shifter and result pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt       <= '0;
            bit_idx   <= '0;
            byte_data <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= (state == RX_IDLE || cnt_hit) ? '0 : cnt + 1'b1;
            if (state == RX_DATA && cnt_hit) begin
                byte_data <= {rx_sync, byte_data[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
            if (state == RX_STOP && cnt_hit) begin
                byte_vld  <= rx_sync;
                frame_err <= !rx_sync;
            end
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// UART-driven memory loader: sync 0xA5, LE base address, LE word count,
// LE data words written one at a time over a req/gnt write port.
// Define UART_LOADER_CKSUM_EN to require a trailing XOR checksum byte.
module uart_mem_loader
    import cc_itf_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  uart_rx_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int BIT_DIV = CLK_FREQ_HZ / BAUD;

`ifdef UART_LOADER_CKSUM_EN
    localparam ld_state_e END_ST = CKSUM;
`else
    localparam ld_state_e END_ST = DONE;
`endif

    ld_state_e              state, state_nxt;
    logic                   byte_vld, frame_err;
    logic [7:0]             byte_data;
    logic [1:0]             byte_cnt;
    logic [31:0]            shreg, shreg_nxt, wdata, remain;
    logic [ADDR_WIDTH-1:0]  addr, addr_in;
    logic [7:0]             cksum, cksum_rx;
    logic                   cksum_pend, word_done, last_word, busy;

    uart_rx_byte #(.BIT_DIV(BIT_DIV)) u_rx (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rx_i      (uart_rx_i),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign shreg_nxt = {byte_data, shreg[31:8]};
    assign addr_in   = ADDR_WIDTH'(shreg_nxt);
    assign word_done = byte_vld && (byte_cnt == 2'd3);
    assign last_word = (remain == 32'd1);
    assign busy      = (state inside {ADDR, LEN, DATA, WRITE, CKSUM});

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // Frame sequencing; a framing error anywhere inside a frame wins
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: if (byte_vld && byte_data == SYNC_BYTE) state_nxt = ADDR;
            ADDR:  if (word_done) state_nxt = LEN;
            LEN:   if (word_done) state_nxt = (shreg_nxt != 32'd0) ? DATA : END_ST;
            DATA:  if (word_done) state_nxt = WRITE;
            WRITE: begin
                if (mem_gnt_i)      state_nxt = last_word ? END_ST : (word_done ? WRITE : DATA);
                else if (word_done) state_nxt = ERR;    // overrun
            end
            CKSUM: begin
                if (cksum_pend)    state_nxt = (cksum_rx == cksum) ? DONE : ERR;
                else if (byte_vld) state_nxt = (byte_data == cksum) ? DONE : ERR;
            end
            default: state_nxt = IDLE;
        endcase
        if (frame_err && busy) state_nxt = ERR;
    end

    // Byte assembly, running checksum, address/count bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt   <= '0;
            shreg      <= '0;
            wdata      <= '0;
            remain     <= '0;
            addr       <= '0;
            cksum      <= '0;
            cksum_rx   <= '0;
            cksum_pend <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    byte_cnt   <= '0;
                    cksum      <= '0;
                    cksum_pend <= 1'b0;
                end
                ADDR, LEN, DATA, WRITE: begin
                    // A byte arriving while the last word is pending is the checksum
                    if (state == WRITE && last_word) begin
                        if (byte_vld) begin
                            cksum_rx   <= byte_data;
                            cksum_pend <= 1'b1;
                        end
                    end else if (byte_vld) begin
                        shreg    <= shreg_nxt;
                        byte_cnt <= byte_cnt + 2'd1;
                        cksum    <= cksum ^ byte_data;
                    end
                    if (word_done) begin
                        unique case (state)
                            ADDR:    addr   <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
                            LEN:     remain <= shreg_nxt;
                            default: wdata  <= shreg_nxt;
                        endcase
                    end
                    if (state == WRITE && mem_gnt_i) begin
                        addr   <= addr + ADDR_WIDTH'(4);
                        remain <= remain - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o   = (state == WRITE);
    assign mem_we_o    = mem_req_o;
    assign mem_be_o    = {4{mem_req_o}};
    assign mem_addr_o  = addr;
    assign mem_wdata_o = wdata;
    assign busy_o      = busy;
    assign done_o      = (state == DONE);
    assign err_o       = (state == ERR);

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader with a frame-level write model.
module tb_uart_mem_loader;
    localparam int CLK_HZ = 1600000;
    localparam int BAUD_R = 100000;
    localparam int BD     = CLK_HZ / BAUD_R;
`ifdef UART_LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1, gnt = 1'b1;
    logic        mem_req_o, mem_we_o, busy_o, done_o, err_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;

    uart_mem_loader #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(rx),
        .mem_req_o(mem_req_o), .mem_gnt_i(gnt), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] log_addr[$], log_data[$];
    logic [31:0] fw[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_cksum(input logic [31:0] base, input logic [31:0] n);
        logic [7:0] c = 8'h00;
        for (int k = 0; k < 4; k++) c = c ^ base[8*k +: 8] ^ n[8*k +: 8];
        foreach (fw[i]) for (int k = 0; k < 4; k++) c = c ^ fw[i][8*k +: 8];
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk) rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) @(negedge clk);
        end
        rx = !bad_stop;
        repeat (BD) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Sends a full frame from fw; queues the writes the frame implies
    task automatic send_frame(input logic [31:0] base, input logic [7:0] ck_flip,
                              input bit expect_writes, output logic [2:0] exp_st);
        logic [31:0] n = 32'(fw.size());
        if (expect_writes)
            foreach (fw[i]) exp_q.push_back({(base & ~32'h3) + 32'(4 * i), fw[i]});
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(base[8*k +: 8], 1'b0);
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 1'b0);
        foreach (fw[i]) for (int k = 0; k < 4; k++) send_byte(fw[i][8*k +: 8], 1'b0);
        if (CK_EN) send_byte(model_cksum(base, n) ^ ck_flip, 1'b0);
        exp_st = (CK_EN && ck_flip != 8'h00) ? 3'b001 : 3'b010;   // {busy,done,err}
        repeat (2 * BD) @(negedge clk);
    endtask

    task automatic frame_end(input string name, input logic [2:0] exp_st);
        check({name, "_status"}, {mem_req_o, busy_o, done_o, err_o}, {1'b0, exp_st});
        check({name, "_pending"}, 96'(exp_q.size()), 96'd0);
    endtask

    // Every-cycle port checks and write scoreboard
    logic        prev_req = 1'b0, prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("excl", {$countones({busy_o, done_o, err_o}) <= 1, mem_req_o && !busy_o}, {1'b1, 1'b0});
            if (mem_req_o) begin
                check("we_be", {mem_we_o, mem_be_o}, {1'b1, 4'hF});
                if (prev_req && !prev_gnt)
                    check("hold", {mem_addr_o, mem_wdata_o}, {prev_addr, prev_data});
                if (gnt) begin
                    log_addr.push_back(mem_addr_o);
                    log_data.push_back(mem_wdata_o);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr_o, mem_wdata_o);
                    end else begin
                        check("write", {mem_addr_o, mem_wdata_o}, exp_q.pop_front());
                    end
                end
            end
        end
        prev_req  <= mem_req_o;
        prev_gnt  <= gnt;
        prev_addr <= mem_addr_o;
        prev_data <= mem_wdata_o;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] st;
        int         t, nlog;
        repeat (4) @(negedge clk);
        check("reset_outputs", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o, done_o, err_o}, 96'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_outputs", {mem_req_o, busy_o, done_o, err_o}, 4'b0000);

        // Basic two-word frame
        fw = '{32'hDEADBEEF, 32'h12345678};
        check("model_cksum", model_cksum(32'h1000, 32'd2), 8'h38);
        send_frame(32'h1000, 8'h00, 1'b1, st);
        frame_end("basic", st);
        check("basic_lit", {log_addr[0], log_data[0], log_addr[1]}, {32'h1000, 32'hDEADBEEF, 32'h1004});
        check("basic_lit2", {done_o, log_data[1]}, {1'b1, 32'h12345678});

        // Corrupted checksum: writes still happen
        send_frame(32'h1000, 8'h01, 1'b1, st);
        frame_end("badck", st);

        // Empty frame (also leaves ERR/DONE via sync byte)
        fw = {};
        send_frame(32'h4000, 8'h00, 1'b1, st);
        frame_end("n0", st);
        check("n0_lit", {done_o, 32'(log_addr.size())}, {1'b1, 32'd4});

        // Unaligned base is forced word-aligned
        fw = '{32'hCAFEF00D};
        send_frame(32'h0000_0102, 8'h00, 1'b1, st);
        frame_end("align", st);
        check("align_lit", log_addr[4], 32'h100);

        // Address wraps at the top of the space
        fw = '{32'h11111111, 32'h22222222};
        send_frame(32'hFFFF_FFFC, 8'h00, 1'b1, st);
        frame_end("wrap", st);
        check("wrap_lit", {log_addr[5], log_addr[6]}, {32'hFFFF_FFFC, 32'h0});

        // Short glitch on the line is not a start bit
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check("glitch", {busy_o, done_o, err_o}, 3'b010);

        // Grant withheld: request holds, then next word overruns
        gnt = 1'b0;
        fw = '{32'h0A0B0C0D, 32'h01020304, 32'h05060708};
        fork
            send_frame(32'h2000, 8'h00, 1'b0, st);
            begin
                t = 0;
                while (!mem_req_o && t < 20000) begin @(negedge clk); t++; end
                check("stall_req_seen", mem_req_o, 1'b1);
                repeat (5 * BD) begin
                    @(negedge clk);
                    check("stall_stable", {mem_req_o, mem_addr_o, mem_wdata_o}, {1'b1, 32'h2000, 32'h0A0B0C0D});
                end
            end
        join
        check("overrun", {mem_req_o, busy_o, done_o, err_o}, 4'b0001);
        gnt = 1'b1;

        // Framing error during LEN
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b1);
        repeat (BD) @(negedge clk);
        check("len_frame_err", {mem_req_o, busy_o, done_o, err_o}, 4'b0001);

        // Reset in the middle of a data word abandons the frame
        nlog = log_addr.size();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        check("mid_data_busy", busy_o, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_outputs", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o, done_o, err_o}, 96'd0);
        rst_n = 1'b1;
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        repeat (2 * BD) @(negedge clk);
        check("after_reset", {mem_req_o, busy_o, done_o, err_o, 32'(log_addr.size())}, {4'b0000, 32'(nlog)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, meaning the clk_i frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the UART bit rate; BIT_DIV = CLK_FREQ_HZ/BAUD, truncated.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning the memory byte-address width.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port uart_rx_i, input, 1 bit: asynchronous serial input, 8N1, idle high.
REQ-007 SHALL have port mem_req_o, output, 1 bit: write request.
REQ-008 SHALL have port mem_gnt_i, input, 1 bit: write accepted.
REQ-009 SHALL have port mem_we_o, output, 1 bit: write enable, 1 whenever mem_req_o=1.
REQ-010 SHALL have port mem_be_o, output, 4 bits: byte enables, 4'hF whenever mem_req_o=1.
REQ-011 SHALL have port mem_addr_o, output, ADDR_WIDTH bits: word-aligned byte address.
REQ-012 SHALL have port mem_wdata_o, output, 32 bits: write data.
REQ-013 SHALL have port busy_o, output, 1 bit: a frame is in progress.
REQ-014 SHALL have port done_o, output, 1 bit: last frame completed OK (level).
REQ-015 SHALL have port err_o, output, 1 bit: last frame failed (level).

Function
REQ-016 SHALL pass uart_rx_i through a 2-flop synchroniser; a falling edge in IDLE starts a bit counter; the start bit is re-sampled at BIT_DIV/2 and aborted if high; data bits are sampled LSB-first every BIT_DIV cycles; a stop bit sampled low is a framing error.
REQ-017 Frame format: sync 0xA5, 4-byte base address (LE), 4-byte word count N (LE), N 4-byte words (LE), 1-byte checksum.
REQ-018 Checksum SHALL be the XOR of all bytes after sync up to and including the last data byte.
REQ-019 FSM states SHALL be IDLE, ADDR, LEN, DATA, WRITE, CKSUM, DONE, ERR.
REQ-020 IDLE: a byte of 0xA5 -> ADDR; any other byte is discarded. ADDR -> LEN after 4 bytes. LEN -> DATA after 4 bytes if N!=0, else -> CKSUM.
REQ-021 DATA -> WRITE after the 4th byte of a word; WRITE drives mem_req_o and holds address and data stable until the cycle mem_gnt_i=1.
REQ-022 On grant: address += 4 (wraps modulo 2^ADDR_WIDTH); remaining count -= 1; -> CKSUM if 0, else -> DATA.
REQ-023 Byte reception SHALL continue during WRITE; a word completed while WRITE is still pending SHALL be an overrun -> ERR.
REQ-024 Base address bits [1:0] SHALL be forced to 0.
REQ-025 CKSUM: a match -> DONE; a mismatch -> ERR.
REQ-026 Any framing error in ADDR, LEN, DATA, WRITE or CKSUM -> ERR; in ERR the pending mem_req_o SHALL drop.
REQ-027 DONE and ERR SHALL behave as IDLE, and a 0xA5 byte in either -> ADDR, clearing done_o/err_o.
REQ-028 busy_o SHALL be 1 in ADDR, LEN, DATA, WRITE, CKSUM; done_o SHALL be 1 only in DONE; err_o SHALL be 1 only in ERR.

Reset
REQ-029 On rst_ni low SHALL enter IDLE with all outputs 0, counters/shift registers 0, and synchroniser flops 1; reset mid-frame SHALL abandon the frame without issuing a write.

Configuration
REQ-030 With UART_LOADER_CKSUM_EN defined, the checksum byte SHALL be received and checked as in REQ-025.
REQ-031 Without UART_LOADER_CKSUM_EN, frames SHALL end after the last data word (or after LEN when N=0) and -> DONE; no checksum byte is expected.

Structure
REQ-032 The sync byte constant and the FSM state enum SHALL live in CC_ITF_PKG.
REQ-033 The bit-level receiver SHALL be sub-module uart_rx_byte, with outputs byte_vld (1-cycle pulse), byte_data[7:0] and frame_err.

Verification
REQ-034 Frame A5, addr 00001000, N=2, words DEADBEEF and 12345678, correct checksum, gnt tied 1 -> writes 0x1000=DEADBEEF and 0x1004=12345678, done_o=1.
REQ-035 Same frame with checksum XOR 0x01 -> both writes occur, err_o=1, done_o=0.
REQ-036 N=0 frame -> no mem_req_o, done_o=1.
REQ-037 Base FFFFFFFC, N=2 -> writes to FFFFFFFC then 00000000.
REQ-038 mem_gnt_i held 0 for 5 bit times -> mem_req_o/addr/data stay stable; then gnt held 0 past the next full word -> err_o=1, mem_req_o=0.
REQ-039 Stop bit forced low during the LEN phase -> err_o=1; rst_ni pulsed mid-DATA -> all outputs 0, no write issued.
